hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_if.sv | 38 +++
 rtl/hazard_unit.sv | 112 +++++++++++
 tb/tb_hazard_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: signal bundle between the pipeline datapath and hazard_unit.
//   master : pipeline side (drives register indices and enables, reads controls)
//   slave  : hazard_unit side
// Signals:
//   Rs1D/Rs2D            decode source registers
//   Rs1E/Rs2E/RdE        execute sources and destination
//   RdM/RdW, RegWriteM/W memory/writeback destinations and write enables
//   ResultSrcE           execute result select (3'b001 = load)
//   PCSrcE, MulStartE    taken branch/jump in E, multi-cycle op in E
//   ForwardAE/BE         operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//   Stall*/Flush*        pipeline control
//   MulDoneE             one-cycle multi-cycle completion pulse
interface hazard_if;
    logic [4:0] Rs1D, Rs2D;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic [4:0] RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [2:0] ResultSrcE;
    logic       PCSrcE, MulStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE;
    logic       FlushD, FlushE, FlushM;
    logic       MulDoneE;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MulStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulDoneE
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MulStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulDoneE
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall, branch flush and multi-cycle
// execute sequencing for a 5-stage pipeline.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   hz     hazard_if.slave bundle (see hazard_if.sv)
//   StallCount/FlushCount (32-bit, only with HAZARD_PERF_EN defined):
//          cycles with StallF=1 / cycles with FlushD or FlushE = 1
// Parameters:
//   MUL_LAT  multi-cycle execute latency, 1..15 (cnt is 4 bits wide)
// Build option: define HAZARD_PERF_EN to add the performance counters.
module hazard_unit #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    hazard_if.slave     hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       busy_stall, mul_done, lw_stall;
    logic       stall_f, flush_d, flush_e;

    // Memory stage wins over Writeback; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.RegWriteM && rs != 5'd0 && hz.RdM == rs)      return 2'b10;
        else if (hz.RegWriteW && rs != 5'd0 && hz.RdW == rs) return 2'b01;
        else                                                 return 2'b00;
    endfunction

    assign lw_stall = (hz.ResultSrcE == 3'b001) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // The start cycle itself stalls, so BUSY needs MUL_LAT-1 more stall
    // cycles before the done cycle. A branch in the same cycle kills the op.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        busy_stall = 1'b0;
        mul_done   = 1'b0;
        case (state)
            IDLE: begin
                if (hz.MulStartE && !hz.PCSrcE) begin
                    busy_stall = 1'b1;
                    state_nx   = BUSY;
                    cnt_nx     = 4'(MUL_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    busy_stall = 1'b1;
                    cnt_nx     = cnt - 4'd1;
                end else begin
                    // MulStartE is deliberately ignored here: the op in E
                    // is finishing, not a new one.
                    mul_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign stall_f = reset ? 1'b0 : (lw_stall || busy_stall);
    assign flush_d = reset ? 1'b1 : hz.PCSrcE;
    // While the multi-cycle op holds E, the load-use bubble must not
    // overwrite it; StallE already holds the instruction.
    assign flush_e = reset ? 1'b1 : (hz.PCSrcE || (lw_stall && !busy_stall));

    always_comb begin
        hz.ForwardAE = reset ? 2'b00 : fwd_sel(hz.Rs1E);
        hz.ForwardBE = reset ? 2'b00 : fwd_sel(hz.Rs2E);
        hz.StallF    = stall_f;
        hz.StallD    = stall_f;
        hz.StallE    = reset ? 1'b0 : busy_stall;
        hz.FlushD    = flush_d;
        hz.FlushE    = flush_e;
        hz.FlushM    = reset ? 1'b1 : busy_stall;
        hz.MulDoneE  = reset ? 1'b0 : mul_done;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (stall_f)            StallCount <= StallCount + 32'd1;
            if (flush_d || flush_e) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed bench for hazard_unit (MUL_LAT=4). Each step drives
// inputs after a falling edge, pushes the expected control vector to a
// scoreboard queue, and pops/compares it shortly after, before the next
// rising edge.
module tb_hazard_unit;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, se, fd, fe, fm, done;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hazard_if hif();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count, flush_count;
    hazard_unit #(.MUL_LAT(4)) dut (
        .clk(clk), .reset(reset), .hz(hif.slave),
        .StallCount(stall_count), .FlushCount(flush_count)
    );
`else
    hazard_unit #(.MUL_LAT(4)) dut (.clk(clk), .reset(reset), .hz(hif.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                input logic sf, input logic sd, input logic se,
                                input logic fd, input logic fe, input logic fm,
                                input logic done);
        exp_t e;
        e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se;
        e.fd = fd; e.fe = fe; e.fm = fm; e.done = done;
        return e;
    endfunction

    task automatic clr();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
        hif.RdM = 0; hif.RdW = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.ResultSrcE = 3'b000; hif.PCSrcE = 0; hif.MulStartE = 0;
    endtask

    // Inputs are already applied by the caller (just after a falling edge).
    task automatic step(input exp_t e, input string tag);
        exp_t got, want;
        sb.push_back(e);
        #2;
        got.fa = hif.ForwardAE; got.fb = hif.ForwardBE;
        got.sf = hif.StallF;    got.sd = hif.StallD;   got.se = hif.StallE;
        got.fd = hif.FlushD;    got.fe = hif.FlushE;   got.fm = hif.FlushM;
        got.done = hif.MulDoneE;
        want = sb.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got fa,fb,sf,sd,se,fd,fe,fm,done=%b expected %b", tag, got, want);
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t Z, R, BZ, DN;
        Z  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        R  = mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0);
        BZ = mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0);
        DN = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);

        clr();
        reset = 1'b1;
        @(negedge clk);

        // Reset forces outputs even with hazards present on the inputs.
        hif.RdM = 5; hif.RegWriteM = 1; hif.Rs1E = 5; hif.MulStartE = 1;
        step(R, "reset0");
        step(R, "reset1");
        clr(); reset = 1'b0;
        step(Z, "idle");

        // Forwarding
        hif.RdM = 5; hif.RdW = 5; hif.RegWriteM = 1; hif.RegWriteW = 1;
        hif.Rs1E = 5; hif.Rs2E = 5;
        step(mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0), "fwd_m_prio");
        hif.RegWriteM = 0;
        step(mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0), "fwd_w");
        hif.Rs1E = 0;
        step(mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0), "fwd_rs1_x0");
        hif.Rs2E = 6;
        step(Z, "fwd_nomatch");
        clr(); hif.RdM = 0; hif.RegWriteM = 1; hif.Rs2E = 0;
        step(Z, "fwd_rdm_x0");

        // Load-use
        clr(); hif.ResultSrcE = 3'b001; hif.RdE = 7; hif.Rs2D = 7;
        step(mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0), "lw_rs2");
        hif.Rs2D = 0; hif.Rs1D = 7;
        step(mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0), "lw_rs1");
        hif.ResultSrcE = 3'b010;
        step(Z, "lw_not_load");
        hif.ResultSrcE = 3'b001; hif.RdE = 0; hif.Rs1D = 0;
        step(Z, "lw_rd_x0");

        // Branch
        clr(); hif.PCSrcE = 1;
        step(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0), "branch");

        // Multi-cycle: 4 stall cycles, then one done cycle with MulStartE
        // still high (must not restart).
        clr(); hif.MulStartE = 1;
        step(BZ, "mul_s0");
        step(BZ, "mul_s1");
        step(BZ, "mul_s2");
        step(BZ, "mul_s3");
        step(DN, "mul_done");
        hif.MulStartE = 0;
        step(Z, "mul_idle");

        // Overlap: load-use and forwarding while BUSY
        hif.MulStartE = 1;
        step(BZ, "ov_s0");
        hif.ResultSrcE = 3'b001; hif.RdE = 7; hif.Rs1D = 7;
        hif.RdM = 5; hif.RegWriteM = 1; hif.Rs1E = 5;
        step(mk(2'b10, 2'b00, 1, 1, 1, 0, 0, 1, 0), "ov_lw_busy");
        clr(); hif.MulStartE = 1;
        step(BZ, "ov_s2");
        step(BZ, "ov_s3");
        step(DN, "ov_done");
        clr();
        step(Z, "ov_idle");

        // Branch and multi-cycle together: branch wins, FSM stays IDLE
        hif.PCSrcE = 1; hif.MulStartE = 1;
        step(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0), "br_mul");
        clr();
        step(Z, "br_mul_idle");

        // Reset after two BUSY cycles: abort with no done pulse
        hif.MulStartE = 1;
        step(BZ, "rst_s0");
        step(BZ, "rst_b1");
        step(BZ, "rst_b2");
        reset = 1'b1;
        step(R, "rst_mid");
        reset = 1'b0; hif.MulStartE = 0;
        step(Z, "rst_idle0");
`ifdef HAZARD_PERF_EN
        checks++;
        assert (stall_count === 32'd0) else begin
            errors++;
            $error("FAIL stall_count_rst got %0d expected 0", stall_count);
        end
`endif
        step(Z, "rst_idle1");
        step(Z, "rst_idle2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
